// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the IF/MEM memory port arbiter.
//   WordSize    : machine word width (data and address), matches WORD_SIZE.
//   arb_state_e : arbiter FSM state encoding.
package mem_port_arbiter_pkg;

  localparam int unsigned WordSize = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIBusy = 2'd1,
    StDBusy = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, variable-latency memory between instruction fetch
// (IF) and data access (MEM stage). A grant latches the winner's request
// into the mem_* registers, which are held until mem_ack. Data has priority
// unless D_STREAK_MAX data grants have been made back-to-back while a fetch
// was waiting, in which case the fetch is forced through.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   i_req/i_addr/i_cancel        : fetch request, PC, fetch redirect
//   i_ready/i_rdata              : fetch completion and instruction
//   d_req/d_we/d_addr/d_wdata    : data request (load/store)
//   d_ready/d_rdata              : data completion and load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : memory interface
//   stall_if, stall_mem          : stalls for the hazard logic
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD         = WordSize,
  parameter int unsigned D_STREAK_MAX = 4,
  parameter int unsigned STREAK_W     = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [WORD-1:0] i_addr,
  input  logic            i_cancel,
  output logic            i_ready,
  output logic [WORD-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_ready,
  output logic [WORD-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  output logic            stall_if,
  output logic            stall_mem
);

  arb_state_e          state_q, state_d;
  logic                cancel_q, cancel_d;
  logic [STREAK_W-1:0] streak_q;

  logic fetch_ok;
  logic at_limit;
  logic grant_d;
  logic grant_i;
  logic busy_ack;

  // A fetch being redirected this cycle is not eligible for a grant.
  assign fetch_ok = i_req & ~i_cancel;
  assign at_limit = (streak_q == STREAK_W'(D_STREAK_MAX));
  assign grant_d  = (state_q == StIdle) & d_req & ~(fetch_ok & at_limit);
  assign grant_i  = (state_q == StIdle) & ~grant_d & fetch_ok;
  assign busy_ack = (state_q != StIdle) & mem_ack;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; no grant at the ack edge, so transactions are
  // separated by at least one idle cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StDBusy;
        end else if (grant_i) begin
          state_d = StIBusy;
        end
      end
      StIBusy, StDBusy: begin
        if (mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Completion and stall outputs
  always_comb begin
    i_ready   = (state_q == StIBusy) & mem_ack & ~cancel_q & ~i_cancel;
    d_ready   = (state_q == StDBusy) & mem_ack;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    stall_if  = i_req & ~i_ready;
    stall_mem = d_req & ~d_ready;
  end

  // A cancelled fetch still runs to completion on memory; the flag only
  // masks its i_ready and is dropped when the transaction ends.
  always_comb begin
    cancel_d = cancel_q;
    if (busy_ack) begin
      cancel_d = 1'b0;
    end else if ((state_q == StIBusy) && i_cancel) begin
      cancel_d = 1'b1;
    end
  end

  // Memory request registers and starvation streak counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cancel_q  <= 1'b0;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cancel_q <= cancel_d;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        // Count only data grants that bypassed a waiting fetch.
        if (!fetch_ok) begin
          streak_q <= '0;
        end else if (!at_limit) begin
          streak_q <= streak_q + STREAK_W'(1);
        end
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        streak_q  <= '0;
      end else if (busy_ack) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: a directed vector table, hand
// sequences for starvation, cancel and reset, then randomized traffic
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int W      = 16;
  localparam int STREAK = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_req, i_cancel, i_ready;
  logic [W-1:0] i_addr, i_rdata;
  logic         d_req, d_we, d_ready;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_cancel  (i_cancel),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int           m_owner;   // 0 none, 1 fetch, 2 data
  bit           m_cancel;
  int           m_streak;
  logic         m_we;
  logic [W-1:0] m_addr, m_wdata;
  int           wait_cnt, lat_cur;
  int           ack_lat;   // -1 = random latency 0..3
  int           stale_pct; // chance of a spurious ack while idle
  bit           e_i_ready, e_d_ready;
  logic         prev_mem_req;
  logic [W-1:0] grant_addrs[$];
  int           cnt_i_ready, cnt_d_ready;

  task automatic model_reset();
    m_owner      = 0;
    m_cancel     = 0;
    m_streak     = 0;
    wait_cnt     = 0;
    lat_cur      = 0;
    prev_mem_req = 1'b0;
    grant_addrs.delete();
    cnt_i_ready  = 0;
    cnt_d_ready  = 0;
  endtask

  task automatic start_txn();
    wait_cnt = 0;
    lat_cur  = (ack_lat >= 0) ? ack_lat : int'($urandom_range(3));
  endtask

  task automatic model_edge();
    bit f_ok;
    f_ok = i_req && !i_cancel;
    if (m_owner == 0) begin
      if (d_req && !(f_ok && m_streak == STREAK)) begin
        m_owner  = 2;
        m_we     = d_we;
        m_addr   = d_addr;
        m_wdata  = d_wdata;
        m_streak = f_ok ? m_streak + 1 : 0;
        start_txn();
      end else if (f_ok) begin
        m_owner  = 1;
        m_we     = 1'b0;
        m_addr   = i_addr;
        m_streak = 0;
        start_txn();
      end
    end else if (mem_ack) begin
      m_owner  = 0;
      m_cancel = 0;
    end else begin
      wait_cnt++;
      if (m_owner == 1 && i_cancel) m_cancel = 1;
    end
  endtask

  // One clock cycle: memory responds, outputs compared mid-cycle, model
  // advances at the edge. Called at posedge+1 with requester inputs set.
  task automatic step();
    if (m_owner != 0) mem_ack = (wait_cnt >= lat_cur);
    else mem_ack = (stale_pct > 0) && (int'($urandom_range(99)) < stale_pct);
    mem_rdata = W'($urandom);
    @(negedge clk);
    e_i_ready = (m_owner == 1) && mem_ack && !m_cancel && !i_cancel;
    e_d_ready = (m_owner == 2) && mem_ack;
    check("mem_req", mem_req, m_owner != 0);
    check("i_ready", i_ready, e_i_ready);
    check("d_ready", d_ready, e_d_ready);
    check("stall_if", stall_if, i_req && !e_i_ready);
    check("stall_mem", stall_mem, d_req && !e_d_ready);
    if (m_owner != 0) begin
      check("mem_we", mem_we, m_we);
      check("mem_addr", mem_addr, m_addr);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_i_ready) check("i_rdata", i_rdata, mem_rdata);
    if (e_d_ready) check("d_rdata", d_rdata, mem_rdata);
    if (mem_req && !prev_mem_req) grant_addrs.push_back(mem_addr);
    prev_mem_req = mem_req;
    if (i_ready) cnt_i_ready++;
    if (d_ready) cnt_d_ready++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    i_req     = 1'b0;
    i_addr    = '0;
    i_cancel  = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         ir;
    logic         ic;
    logic [W-1:0] ia;
    logic         dr;
    logic         dw;
    logic [W-1:0] da;
    logic [W-1:0] dwd;
    logic         ack;
    logic [W-1:0] rd;
    logic         e_mreq;
    logic         e_mwe;
    logic [W-1:0] e_maddr;
    logic [W-1:0] e_mwdata;
    logic         e_ir;
    logic         e_dr;
    logic         e_sif;
    logic         e_smem;
  } vec_t;

  vec_t vecs[13];

  task automatic run_table();
    // Fetch alone, ack latency 0
    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,
                 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h6A05,
                 1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,
                 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Store alone, ack on third busy cycle
    vecs[3]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0,
                 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0,
                 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = vecs[4];
    vecs[6]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h0,
                 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = vecs[2];
    // Contention: data first, idle cycle, then fetch
    vecs[8]  = '{1'b1, 1'b0, 16'h0020, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0,
                 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0020, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 16'h1234,
                 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0,
                 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h5555,
                 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    // Stray ack while idle must be ignored
    vecs[12] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h7777,
                 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      i_req     = vecs[i].ir;
      i_cancel  = vecs[i].ic;
      i_addr    = vecs[i].ia;
      d_req     = vecs[i].dr;
      d_we      = vecs[i].dw;
      d_addr    = vecs[i].da;
      d_wdata   = vecs[i].dwd;
      mem_ack   = vecs[i].ack;
      mem_rdata = vecs[i].rd;
      @(negedge clk);
      check($sformatf("tbl%0d_mem_req", i), mem_req, vecs[i].e_mreq);
      if (vecs[i].e_mreq) begin
        check($sformatf("tbl%0d_mem_we", i), mem_we, vecs[i].e_mwe);
        check($sformatf("tbl%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
        if (vecs[i].e_mwe) check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      end
      check($sformatf("tbl%0d_i_ready", i), i_ready, vecs[i].e_ir);
      check($sformatf("tbl%0d_d_ready", i), d_ready, vecs[i].e_dr);
      check($sformatf("tbl%0d_stall_if", i), stall_if, vecs[i].e_sif);
      check($sformatf("tbl%0d_stall_mem", i), stall_mem, vecs[i].e_smem);
      if (vecs[i].e_ir) check($sformatf("tbl%0d_i_rdata", i), i_rdata, vecs[i].rd);
      if (vecs[i].e_dr) check($sformatf("tbl%0d_d_rdata", i), d_rdata, vecs[i].rd);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- hand sequences ----------------
  task automatic test_starvation();
    int           d_done;
    logic [W-1:0] exp_g[7];
    exp_g = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0100, 16'h0204, 16'h0205};
    do_reset();
    ack_lat   = 0;
    stale_pct = 0;
    i_req     = 1'b1;
    i_addr    = 16'h0100;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 16'h0200;
    d_wdata   = 16'hA000;
    d_done    = 0;
    for (int c = 0; c < 100 && d_done < 6; c++) begin
      step();
      if (e_i_ready) i_req = 1'b0;
      if (e_d_ready) begin
        d_done++;
        if (d_done < 6) begin
          d_addr  = W'(16'h0200 + d_done);
          d_we    = d_done[0];
          d_wdata = W'(16'hA000 + d_done);
        end else begin
          d_req = 1'b0;
        end
      end
    end
    check("starve_grant_count", grant_addrs.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < grant_addrs.size()) check($sformatf("starve_grant%0d", k), grant_addrs[k], exp_g[k]);
    end
    check("starve_fetch_ready_count", cnt_i_ready, 1);
    check("starve_data_ready_count", cnt_d_ready, 6);
  endtask

  task automatic test_cancel();
    bit done;
    do_reset();
    ack_lat   = 2;
    stale_pct = 0;
    i_req     = 1'b1;
    i_addr    = 16'h0300;
    step();                 // grant of 0x0300
    i_cancel  = 1'b1;
    i_addr    = 16'h0340;   // redirect
    step();
    i_cancel  = 1'b0;
    ack_lat   = 0;
    step();
    step();                 // memory completes the killed fetch
    check("cancel_no_ready", cnt_i_ready, 0);
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (e_i_ready) begin
        done  = 1;
        i_req = 1'b0;
      end
    end
    check("cancel_refetch_ready", cnt_i_ready, 1);
    check("cancel_grant_count", grant_addrs.size(), 2);
    if (grant_addrs.size() == 2) begin
      check("cancel_grant0", grant_addrs[0], 16'h0300);
      check("cancel_grant1", grant_addrs[1], 16'h0340);
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    do_reset();
    ack_lat   = 3;
    stale_pct = 0;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 16'h0444;
    d_wdata   = 16'h1111;
    step();
    step();                 // now waiting in the data transaction
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_mem_req", mem_req, 1'b0);
    check("rstmid_mem_we", mem_we, 1'b0);
    check("rstmid_mem_addr", mem_addr, 16'h0000);
    mem_ack = 1'b1;
    #1;
    check("rstmid_d_ready", d_ready, 1'b0);
    check("rstmid_i_ready", i_ready, 1'b0);
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    stale_pct = 100;        // late ack after reset
    step();
    stale_pct = 0;
    check("rstmid_stale_no_ready", cnt_d_ready + cnt_i_ready, 0);
    ack_lat = 1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 16'h0555;
    done    = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      if (e_d_ready) begin
        done  = 1;
        d_req = 1'b0;
      end
    end
    check("rstmid_new_ready", cnt_d_ready, 1);
    check("rstmid_new_grants", grant_addrs.size(), 1);
    if (grant_addrs.size() == 1) check("rstmid_new_addr", grant_addrs[0], 16'h0555);
  endtask

  // ---------------- randomized traffic ----------------
  task automatic test_random();
    do_reset();
    ack_lat   = -1;
    stale_pct = 10;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (e_i_ready || !i_req) begin
        i_req  = (int'($urandom_range(99)) < 60);
        i_addr = W'($urandom);
      end
      i_cancel = (int'($urandom_range(99)) < 8);
      if (i_cancel && i_req) i_addr = W'($urandom);
      if (e_d_ready || !d_req) begin
        d_req   = (int'($urandom_range(99)) < 50);
        d_we    = 1'($urandom_range(1));
        d_addr  = W'($urandom);
        d_wdata = W'($urandom);
      end
    end
  endtask

  initial begin
    ack_lat   = 0;
    stale_pct = 0;
    model_reset();
    do_reset();
    run_table();
    test_starvation();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares one single-port, variable-latency memory between the pipelined CPU's instruction fetch (IF) and data access (MEM stage, LWD/SWD).
- Arbitrates requests and holds the memory transaction until acknowledged.
- Returns data and completion to the winning stage, and generates IF/MEM stall signals for the hazard logic.
- Sits between the pipeline datapath and the external memory model.

Parameters:
- WORD, 16, data and address width; equals `WORD_SIZE.
- D_STREAK_MAX, 4, maximum consecutive data grants while a fetch is pending before fetch is forced.
- STREAK_W, 3, width of the streak counter; must hold D_STREAK_MAX.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ready or i_cancel.
- i_addr  in  WORD  fetch address (PC).
- i_cancel  in  1  fetch redirect (branch/jump resolved); kills the pending or in-flight fetch.
- i_ready  out  1  fetch complete; i_rdata valid this cycle.
- i_rdata  out  WORD  fetched instruction.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = SWD write, 0 = LWD read.
- d_addr  in  WORD  data address.
- d_wdata  in  WORD  store data.
- d_ready  out  1  data access complete; d_rdata valid this cycle for reads.
- d_rdata  out  WORD  load data.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  memory write enable.
- mem_addr  out  WORD  memory address.
- mem_wdata  out  WORD  memory write data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  WORD  read data; valid when mem_ack=1.
- stall_if  out  1  IF must hold PC/IR.
- stall_mem  out  1  MEM and older stages must hold.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, cancel_flag=0, streak=0.
  - Registered outputs mem_req, mem_we, mem_addr and mem_wdata are all 0.
  - Any in-flight memory transaction is abandoned; a late mem_ack is ignored in IDLE.
- States:
  - IDLE: no transaction.
  - I_BUSY: fetch outstanding.
  - D_BUSY: data access outstanding.
- Grant, evaluated at a clock edge while in IDLE:
  - Eligible fetch: i_req=1 and i_cancel=0.
  - Data has priority: if d_req=1 and not (fetch eligible and streak==D_STREAK_MAX), go to D_BUSY.
  - Otherwise, if fetch is eligible, go to I_BUSY.
  - On grant, latch the winner's address, we and wdata into mem_* registers and set mem_req=1 from the next cycle. A fetch grant forces mem_we=0.
- Streak counter:
  - On a data grant with fetch eligible: streak+1.
  - On a data grant with no fetch eligible: streak=0.
  - On a fetch grant: streak=0.
  - The counter never exceeds D_STREAK_MAX.
- While busy:
  - mem_req and the mem_* registers are held stable until mem_ack.
  - On mem_ack, return to IDLE and drop mem_req at that edge.
  - No new grant is made at the ack edge; the earliest next grant is one cycle later, so back-to-back transactions have one idle cycle between them.
- Completion (combinational):
  - i_ready = (I_BUSY & mem_ack & !cancel_flag & !i_cancel).
  - d_ready = (D_BUSY & mem_ack).
  - i_rdata = d_rdata = mem_rdata.
- Cancel:
  - i_cancel in I_BUSY sets cancel_flag; the fetch completes on memory but i_ready is suppressed. cancel_flag clears on return to IDLE.
  - i_cancel in IDLE blocks the fetch grant that cycle.
  - i_cancel has no effect on D_BUSY.
- Stalls (combinational):
  - stall_if = i_req & !i_ready.
  - stall_mem = d_req & !d_ready.
- Latency:
  - Minimum request-to-ready latency is 2 cycles: grant edge, then mem_ack in the next cycle.
  - Latency is otherwise memory-bound, with no timeout.
- Simultaneous i_req and d_req with streak<D_STREAK_MAX: data wins; fetch waits, holding stall_if.
- Request-protocol violations (requester drops req before ready) are undefined; the assertion bench flags them.

Decomposition:
- Shared package or include: state encoding (IDLE, I_BUSY, D_BUSY) and WORD taken from `WORD_SIZE in opcodes.v.
- Single module; the streak counter stays inline. No sub-module is warranted.

Test Plan:
- Fetch alone, ack latency 0:
  - i_req=1, i_addr=0x0010 at cycle 0; memory acks in cycle 1 with 0x6A05.
  - Expect mem_req=1, mem_addr=0x0010, mem_we=0 in cycle 1, and i_ready=1 with i_rdata=0x6A05 in cycle 1.
  - stall_if=1 in cycle 0 only.
- Store alone, ack after 3 cycles:
  - d_req=1, d_we=1, d_addr=0x0040, d_wdata=0xBEEF.
  - Expect mem_we=1 and mem_wdata=0xBEEF held for 3 cycles, d_ready on the ack cycle, and stall_mem high until then.
- Contention:
  - i_req and d_req both high, streak=0.
  - Expect data served first, one idle cycle, then fetch served; streak returns to 0.
- Starvation guard:
  - i_req held high; d_req re-asserted continuously for 6 requests.
  - Expect data grants 1–4, then a fetch grant, then data resumes.
- Cancel in flight:
  - i_cancel pulsed in I_BUSY, ack 2 cycles later.
  - Expect no i_ready, return to IDLE, and a new fetch with the redirected address granted on the next eligible edge.
- Reset mid-transaction:
  - reset_n low during D_BUSY.
  - Expect mem_req=0 immediately, with no d_ready or i_ready asserted.
  - After release, a stale mem_ack produces no ready; a new request is granted normally.
